// File: rtl/seg_display_pkg.sv
// Shared definitions for the eight-digit seven-segment display path:
// digit geometry, IO register addresses, converter state encoding and glyph table.
package seg_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned BIN_WIDTH  = 24;
  localparam int unsigned BCD_WIDTH  = 4 * NUM_DIGITS;

  // IO block registers that feed seg_value and blink
  localparam logic [31:0] IO_SEG_ADDR   = 32'h0000_0010;
  localparam logic [31:0] IO_BLINK_ADDR = 32'h0000_0014;

  typedef enum logic [1:0] {
    DD_IDLE,
    DD_SHIFT,
    DD_LOAD
  } dd_state_t;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'h7F;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      4'hF: g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter; one bit per cycle.
// A start seen while busy is remembered and served straight out of LOAD.
module bin2bcd_seq
  import seg_display_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] value,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_WIDTH-1:0] bcd
);

  dd_state_t            state, state_next;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BCD_WIDTH-1:0] acc_q;
  logic [BCD_WIDTH-1:0] acc_adj;
  logic [4:0]           iter_q;
  logic                 pending_q;
  logic                 restart;

  assign busy    = (state != DD_IDLE);
  assign restart = pending_q || start;

  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DD_IDLE:  if (start) state_next = DD_SHIFT;
      DD_SHIFT: if (iter_q == 5'(BIN_WIDTH - 1)) state_next = DD_LOAD;
      DD_LOAD:  state_next = restart ? DD_SHIFT : DD_IDLE;
      default:  state_next = DD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DD_IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      pending_q <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      state <= state_next;
      done  <= (state == DD_LOAD);
      case (state)
        DD_IDLE: begin
          if (start) begin
            bin_q  <= value;
            acc_q  <= '0;
            iter_q <= '0;
          end
        end
        DD_SHIFT: begin
          {acc_q, bin_q} <= {acc_adj, bin_q} << 1;
          iter_q         <= iter_q + 5'd1;
          if (start) pending_q <= 1'b1;
        end
        DD_LOAD: begin
          bcd       <= acc_q;
          pending_q <= 1'b0;
          // value always equals the latest captured source here
          if (restart) begin
            bin_q  <= value;
            acc_q  <= '0;
            iter_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// Eight-digit multiplexed seven-segment driver: hex or decimal formatting,
// leading-zero blanking, digit scanning and whole-display blink.
module seg_display_driver
  import seg_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIN_WIDTH-1:0] seg_value,
  input  logic                 blink,
  input  logic                 hex_mode,
  output logic [7:0]           seg_an,
  output logic [7:0]           seg_cath,
  output logic                 busy
);

  localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
  localparam int unsigned FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BIN_WIDTH-1:0]       src_value_q;
  logic                       src_hex_q;
  logic                       change;
  logic                       conv_start;
  logic                       conv_done;
  logic [BCD_WIDTH-1:0]       conv_bcd;
  logic [NUM_DIGITS-1:0]      dec_blank;
  logic                       nonzero_above;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      blank;
  logic [SCAN_W-1:0]          scan_cnt;
  logic [IDX_W-1:0]           idx;
  logic [FRAME_W-1:0]         frame_cnt;
  logic                       phase;
  logic                       scan_wrap;
  logic                       frame_wrap;

  assign change     = (seg_value != src_value_q) || (hex_mode != src_hex_q);
  assign conv_start = change && !hex_mode;
  assign scan_wrap  = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign frame_wrap = scan_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .value (seg_value),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Blank from the top down until the first nonzero digit; digit 0 always shows
  always_comb begin
    dec_blank     = '0;
    nonzero_above = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      nonzero_above = nonzero_above || (conv_bcd[4*(NUM_DIGITS-1-k) +: 4] != 4'd0);
      dec_blank[NUM_DIGITS-1-k] = !nonzero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_value_q <= '0;
      src_hex_q   <= 1'b0;
      digits      <= '0;
      blank       <= 8'hFE;
    end else begin
      src_value_q <= seg_value;
      src_hex_q   <= hex_mode;
      // A result finishing after a switch to hex is stale and dropped
      if (change && hex_mode) begin
        digits <= {8'h00, seg_value};
        blank  <= 8'hC0;
      end else if (conv_done && !src_hex_q) begin
        digits <= conv_bcd;
        blank  <= dec_blank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (!blink) begin
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_W'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        phase     <= ~phase;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_an   <= '1;
      seg_cath <= '1;
    end else if (blank[idx]) begin
      seg_an   <= '1;
      seg_cath <= '1;
    end else begin
      seg_an   <= (blink && phase) ? 8'hFF : ~(8'b1 << idx);
      seg_cath <= {1'b1, glyph(digits[idx])};
    end
  end

endmodule
